temporal_decode_32: RTL
=======================

# temporal_decode_32

Temporal-to-binary decoder sitting at the output of the 32-input bitonic sorter. It converts the race-coded edge on each line back into a binary arrival time. After a `start` strobe it counts clock cycles and latches, per line, the cycle on which that line first goes high. It then streams the 32 captured times out over a valid/ready interface and reports whether the times are non-decreasing in line order, which is the sortedness check for the sorter.

## Interface
Parameters:
- `N_LINES`, default 32: number of temporal input lines; must be a power of two.
- `T_WIDTH`, default 7: width of the cycle counter and captured times.
- `T_MAX`, default 69: last cycle of the measurement window; must be < 2^T_WIDTH.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a measurement; honoured only in IDLE.
- `lines_in[0:N_LINES-1]`, input, N_LINES: temporal lines, already synchronous to `clk`; a 0→1 transition marks arrival.
- `busy`, output, 1: high in MEASURE and DRAIN.
- `out_valid`, output, 1: `out_idx`, `out_time` and `out_miss` are valid.
- `out_ready`, input, 1: consumer accepts the current word.
- `out_idx`, output, log2(N_LINES): line index of the current word.
- `out_time`, output, T_WIDTH: captured arrival cycle.
- `out_miss`, output, 1: the line never arrived within the window.
- `done`, output, 1: one-cycle pulse on the last accepted word.
- `sorted_ok`, output, 1: valid when `done` is high; 1 iff the times are non-decreasing from index 0 to N_LINES-1.

## Operation
- **FSM states: IDLE, MEASURE, DRAIN.**
- **IDLE:**
  - `start` clears the counter, all captured flags and the sort tracker.
  - The state becomes MEASURE on the next edge.
- **MEASURE:**
  - The counter value `t` is 0 on the first MEASURE cycle and increments by 1 each cycle.
  - Each line that is high and not yet captured latches `t` and sets its captured flag.
  - Once captured, a line is frozen: later toggles are ignored.
  - A line already high on the first MEASURE cycle captures 0.
  - Exit to DRAIN after the cycle on which every line is captured, or after the cycle with `t == T_MAX`, whichever comes first.
  - On exit, uncaptured lines are loaded with time T_MAX and `miss = 1`.
  - A line rising exactly at `t == T_MAX` captures T_MAX with `miss = 0`.
- **DRAIN:**
  - Words are presented in index order 0 to N_LINES-1; a word advances on `out_valid && out_ready`.
  - The sort tracker compares each accepted `out_time` with the previous one; any decrease clears `sorted_ok`.
  - Missed lines take part in the comparison with value T_MAX.
  - Acceptance of index N_LINES-1 pulses `done` with the final `sorted_ok`, then returns to IDLE.
- `start` is ignored while `busy`.
- The counter saturates at T_MAX and never wraps.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `out_valid`, `done` = 0;
  - `out_idx`, `out_time`, `out_miss` = 0;
  - `sorted_ok` = 1;
  - all captured flags and times cleared.
- Reset asserted mid-MEASURE or mid-DRAIN aborts immediately to the reset values; no partial `done` is issued.
- `start` sampled at edge k:
  - `busy` = 1 from k+1;
  - the first capture cycle is k+1, with `t = 0`.
- Capture is registered: a line high during cycle `t` shows its time in the array at the following edge.
- `out_valid` rises on the first DRAIN cycle and stays high, with stable data, until accepted.
- Zero-bubble streaming: with `out_ready` held high, one word is accepted per cycle, so DRAIN lasts exactly N_LINES cycles.
- `done` and `sorted_ok` are valid in the same cycle as the final handshake; the next cycle is IDLE with `busy` = 0.
- `start` in the same cycle as the final handshake is ignored, because the block is still busy.

## Structure
- Shared package `temporal_pkg`:
  - state enum {IDLE, MEASURE, DRAIN};
  - `T_WIDTH` / `T_MAX` defaults;
  - `time_t` typedef (`logic [T_WIDTH-1:0]`).
- Sub-module `temporal_capture_lane`, instantiated N_LINES times. Per line it holds:
  - the captured flag;
  - the time register;
  - the miss flag.
  
  Inputs: line, counter, measure-enable, clear, finalize.
- The top level holds the FSM, the counter, the all-captured AND-reduce, the output mux and the sort tracker.

## Test plan
- **Reset:** pulse `rst_n` low mid-MEASURE → all outputs at reset values, state IDLE, next `start` measures cleanly from `t = 0`.
- **Ascending arrivals:** line i rises at `t = 2i` → words 0..31 carry times 0, 2, …, 62 with `miss = 0`; `done` with `sorted_ok = 1`; DRAIN takes 32 cycles with `out_ready` = 1.
- **Unsorted input (random race-coded values 0–64):** captured times equal the stimulus times; `sorted_ok = 0` when any adjacent pair is inverted.
- **Timeout:** lines 30 and 31 never rise → those words carry `time = 69`, `miss = 1`; MEASURE lasts 70 cycles; `sorted_ok = 1` if the others ascend.
- **Early exit:** all lines high at `t = 0` → all times 0; MEASURE lasts 1 cycle; `sorted_ok = 1`.
- **Backpressure:** random `out_ready` with ~50% duty → data is held stable while stalled, no word is lost or duplicated, `done` coincides with the index-31 handshake, and `start` pulses during DRAIN are ignored.

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared definitions for the temporal-to-binary decoder: FSM encoding,
// default window parameters and the captured-time type.
package temporal_pkg;

  localparam int TP_T_WIDTH = 7;
  localparam int TP_T_MAX   = 69;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    MEASURE = ST_MEASURE,
    DRAIN   = ST_DRAIN
  } state_e;

  typedef logic [TP_T_WIDTH-1:0] time_t;

endpackage

// File: rtl/temporal_capture_lane.sv
// One temporal line: latches the counter on the first high cycle, then freezes.
// Lines still uncaptured when the window closes are loaded with T_MAX and flagged missed.
module temporal_capture_lane
  import temporal_pkg::*;
#(
  parameter int T_WIDTH = TP_T_WIDTH,
  parameter int T_MAX   = TP_T_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_i,
  input  logic [T_WIDTH-1:0] t_i,
  input  logic               meas_en_i,
  input  logic               clear_i,
  input  logic               finalize_i,
  output logic               captured_o,
  output logic [T_WIDTH-1:0] time_o,
  output logic               miss_o
);

  logic               cap_q, cap_d;
  logic [T_WIDTH-1:0] time_q, time_d;
  logic               miss_q, miss_d;

  // A rise on the closing cycle wins over finalize, so t == T_MAX is a hit, not a miss.
  always_comb begin
    cap_d  = cap_q;
    time_d = time_q;
    miss_d = miss_q;
    if (clear_i) begin
      cap_d  = 1'b0;
      time_d = '0;
      miss_d = 1'b0;
    end else if (meas_en_i && line_i && !cap_q) begin
      cap_d  = 1'b1;
      time_d = t_i;
    end else if (finalize_i && !cap_q) begin
      time_d = T_WIDTH'(T_MAX);
      miss_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q  <= 1'b0;
      time_q <= '0;
      miss_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      time_q <= time_d;
      miss_q <= miss_d;
    end
  end

  assign captured_o = cap_q;
  assign time_o     = time_q;
  assign miss_o     = miss_q;

endmodule

// File: rtl/temporal_decode_32.sv
// Temporal-to-binary decoder for the bitonic sorter output: measures per-line
// arrival cycles, then streams them out in index order with a sortedness verdict.
module temporal_decode_32
  import temporal_pkg::*;
#(
  parameter int N_LINES = 32,
  parameter int T_WIDTH = TP_T_WIDTH,
  parameter int T_MAX   = TP_T_MAX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_LINES-1:0]         lines_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_LINES)-1:0] out_idx,
  output logic [T_WIDTH-1:0]         out_time,
  output logic                       out_miss,
  output logic                       done,
  output logic                       sorted_ok
);

  localparam int                 IDX_W    = $clog2(N_LINES);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_LINES - 1);
  localparam logic [T_WIDTH-1:0] TMAX_T   = T_WIDTH'(T_MAX);

  state_e             state_q, state_d;
  logic [T_WIDTH-1:0] cnt_q, cnt_d;
  logic [T_WIDTH-1:0] prev_q, prev_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sorted_q, sorted_d;

  logic [N_LINES-1:0] cap;
  logic [N_LINES-1:0] miss_arr;
  logic [T_WIDTH-1:0] time_arr [N_LINES];

  logic               in_idle, in_meas, in_drain;
  logic               go, meas_exit, accept, last_word, decrease;
  logic [T_WIDTH-1:0] cur_time;

  assign in_idle  = (state_q == IDLE);
  assign in_meas  = (state_q == MEASURE);
  assign in_drain = (state_q == DRAIN);
  assign go       = in_idle && start;

  // Leave after the cycle that completes the set, looking at lines rising this cycle too.
  assign meas_exit = in_meas && ((&(cap | lines_in)) || (cnt_q == TMAX_T));

  assign cur_time  = time_arr[idx_q];
  assign accept    = in_drain && out_ready;
  assign last_word = (idx_q == IDX_LAST);
  assign decrease  = accept && (cur_time < prev_q);

  for (genvar i = 0; i < N_LINES; i++) begin : g_lane
    temporal_capture_lane #(
      .T_WIDTH (T_WIDTH),
      .T_MAX   (T_MAX)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_i     (lines_in[i]),
      .t_i        (cnt_q),
      .meas_en_i  (in_meas),
      .clear_i    (go),
      .finalize_i (meas_exit),
      .captured_o (cap[i]),
      .time_o     (time_arr[i]),
      .miss_o     (miss_arr[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    idx_d    = idx_q;
    sorted_d = sorted_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MEASURE;
          cnt_d    = '0;
          prev_d   = '0;
          idx_d    = '0;
          sorted_d = 1'b1;
        end
      end
      MEASURE: begin
        if (cnt_q != TMAX_T) cnt_d = cnt_q + 1'b1;
        if (meas_exit) state_d = DRAIN;
      end
      DRAIN: begin
        if (accept) begin
          prev_d = cur_time;
          if (decrease) sorted_d = 1'b0;
          if (last_word) state_d = IDLE;
          else           idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      sorted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      sorted_q <= sorted_d;
    end
  end

  // Data outputs read as zero outside DRAIN; the verdict folds in the word being accepted now.
  assign busy      = in_meas || in_drain;
  assign out_valid = in_drain;
  assign out_idx   = in_drain ? idx_q : '0;
  assign out_time  = in_drain ? cur_time : '0;
  assign out_miss  = in_drain && miss_arr[idx_q];
  assign done      = accept && last_word;
  assign sorted_ok = sorted_q && !decrease;

endmodule
